// File: rtl/sprite_loc_ctrl_if.sv
// Controller-side bus of sprite_loc_ctrl: wall-map read port plus the
// move handshake towards the map-RAM writer.
interface sprite_loc_ctrl_if #(
  parameter int X_W  = 6,
  parameter int Y_W  = 5,
  parameter int ID_W = 2
);
  logic            wall_rd_en;
  logic [X_W-1:0]  wall_rd_x;
  logic [Y_W-1:0]  wall_rd_y;
  logic            wall_rd_data;
  logic            wr_req;
  logic [ID_W-1:0] wr_id;
  logic [X_W-1:0]  wr_old_x;
  logic [Y_W-1:0]  wr_old_y;
  logic [X_W-1:0]  wr_new_x;
  logic [Y_W-1:0]  wr_new_y;
  logic            done;

  modport master (
    output wall_rd_en, wall_rd_x, wall_rd_y,
    output wr_req, wr_id, wr_old_x, wr_old_y, wr_new_x, wr_new_y,
    input  wall_rd_data, done
  );

  modport slave (
    input  wall_rd_en, wall_rd_x, wall_rd_y,
    input  wr_req, wr_id, wr_old_x, wr_old_y, wr_new_x, wr_new_y,
    output wall_rd_data, done
  );
endinterface

// File: rtl/sprite_loc_ctrl.sv
// Sprite location controller: round-robin move arbitration, wall check and
// hand-off to the map-RAM writer. Define SPRITE_WRAP_EN to wrap at map edges.
module sprite_loc_ctrl #(
  parameter int NUM_SPR = 4,
  parameter int X_W     = 6,
  parameter int Y_W     = 5,
  parameter int MAP_W   = 40,
  parameter int MAP_H   = 30,
  parameter logic [NUM_SPR*(X_W+Y_W)-1:0] START_XY = {NUM_SPR{6'd20, 5'd20}},
  parameter int ID_W    = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1
) (
  input  logic                    CLOCK_50,
  input  logic                    reset_n,
  input  logic [4*NUM_SPR-1:0]    dir,
  sprite_loc_ctrl_if.master       bus,
  output logic                    blocked,
  output logic [ID_W-1:0]         blocked_id,
  output logic [NUM_SPR*X_W-1:0]  curr_x,
  output logic [NUM_SPR*Y_W-1:0]  curr_y,
  output logic                    busy
);

  localparam int XY_W = X_W + Y_W;
  localparam logic [X_W-1:0]  X_MAX   = X_W'(MAP_W - 1);
  localparam logic [Y_W-1:0]  Y_MAX   = Y_W'(MAP_H - 1);
  localparam logic [X_W-1:0]  X_ONE   = X_W'(1);
  localparam logic [Y_W-1:0]  Y_ONE   = Y_W'(1);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_SPR - 1);
`ifdef SPRITE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    if (id == LAST_ID) begin
      return '0;
    end else begin
      return id + ID_W'(1);
    end
  endfunction

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] cur_id;
  logic [X_W-1:0]  pos_x [NUM_SPR];
  logic [Y_W-1:0]  pos_y [NUM_SPR];
  logic [X_W-1:0]  old_x;
  logic [Y_W-1:0]  old_y;
  logic [X_W-1:0]  cand_x;
  logic [Y_W-1:0]  cand_y;

  logic            found;
  logic [ID_W-1:0] sel_id;
  logic [3:0]      sel_dir;
  logic [X_W-1:0]  sel_x;
  logic [Y_W-1:0]  sel_y;
  logic [X_W-1:0]  nxt_x;
  logic [Y_W-1:0]  nxt_y;
  logic            at_edge;
  logic            edge_rej;

  // Round-robin search: first sprite at or after rr_ptr with a direction held.
  always_comb begin
    int idx;
    idx     = 0;
    found   = 1'b0;
    sel_id  = rr_ptr;
    sel_dir = 4'd0;
    for (int k = 0; k < NUM_SPR; k++) begin
      idx = int'(rr_ptr) + k;
      idx = (idx >= NUM_SPR) ? idx - NUM_SPR : idx;
      if (!found && (dir[4*idx +: 4] != 4'd0)) begin
        found   = 1'b1;
        sel_id  = ID_W'(idx);
        sel_dir = dir[4*idx +: 4];
      end else begin
        found   = found;
      end
    end
  end

  assign sel_x = pos_x[sel_id];
  assign sel_y = pos_y[sel_id];

  // Candidate tile, priority up > down > left > right; edges always wrap here
  // and are rejected afterwards when wrapping is disabled.
  always_comb begin
    nxt_x   = sel_x;
    nxt_y   = sel_y;
    at_edge = 1'b0;
    if (sel_dir[3]) begin
      at_edge = (sel_y == '0);
      nxt_y   = at_edge ? Y_MAX : sel_y - Y_ONE;
    end else if (sel_dir[2]) begin
      at_edge = (sel_y == Y_MAX);
      nxt_y   = at_edge ? '0 : sel_y + Y_ONE;
    end else if (sel_dir[1]) begin
      at_edge = (sel_x == '0);
      nxt_x   = at_edge ? X_MAX : sel_x - X_ONE;
    end else if (sel_dir[0]) begin
      at_edge = (sel_x == X_MAX);
      nxt_x   = at_edge ? '0 : sel_x + X_ONE;
    end else begin
      at_edge = 1'b0;
    end
  end

  assign edge_rej = at_edge && !WRAP;

  for (genvar i = 0; i < NUM_SPR; i++) begin : g_curr
    assign curr_x[i*X_W +: X_W] = pos_x[i];
    assign curr_y[i*Y_W +: Y_W] = pos_y[i];
  end

  assign busy = (state != ST_IDLE);

  // Move FSM: latch request, read wall map, hand the move to the writer.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      rr_ptr         <= '0;
      cur_id         <= '0;
      old_x          <= '0;
      old_y          <= '0;
      cand_x         <= '0;
      cand_y         <= '0;
      blocked        <= 1'b0;
      blocked_id     <= '0;
      bus.wall_rd_en <= 1'b0;
      bus.wall_rd_x  <= '0;
      bus.wall_rd_y  <= '0;
      bus.wr_req     <= 1'b0;
      bus.wr_id      <= '0;
      bus.wr_old_x   <= '0;
      bus.wr_old_y   <= '0;
      bus.wr_new_x   <= '0;
      bus.wr_new_y   <= '0;
      for (int i = 0; i < NUM_SPR; i++) begin
        pos_x[i] <= START_XY[i*XY_W + Y_W +: X_W];
        pos_y[i] <= START_XY[i*XY_W +: Y_W];
      end
    end else begin
      blocked        <= 1'b0;
      bus.wall_rd_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (found) begin
            cur_id <= sel_id;
            old_x  <= sel_x;
            old_y  <= sel_y;
            cand_x <= nxt_x;
            cand_y <= nxt_y;
            if (edge_rej) begin
              blocked    <= 1'b1;
              blocked_id <= sel_id;
              rr_ptr     <= next_id(sel_id);
            end else begin
              state          <= ST_CHECK;
              bus.wall_rd_en <= 1'b1;
              bus.wall_rd_x  <= nxt_x;
              bus.wall_rd_y  <= nxt_y;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CHECK: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.wall_rd_data) begin
            blocked    <= 1'b1;
            blocked_id <= cur_id;
            rr_ptr     <= next_id(cur_id);
            state      <= ST_IDLE;
          end else begin
            state        <= ST_WRITE;
            bus.wr_req   <= 1'b1;
            bus.wr_id    <= cur_id;
            bus.wr_old_x <= old_x;
            bus.wr_old_y <= old_y;
            bus.wr_new_x <= cand_x;
            bus.wr_new_y <= cand_y;
          end
        end
        ST_WRITE: begin
          if (bus.done) begin
            pos_x[cur_id] <= cand_x;
            pos_y[cur_id] <= cand_y;
            bus.wr_req    <= 1'b0;
            rr_ptr        <= next_id(cur_id);
            state         <= ST_IDLE;
          end else begin
            state <= ST_WRITE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_loc_ctrl.sv
// Scoreboard bench for sprite_loc_ctrl: expected moves/rejections are queued
// by the stimulus and popped by a monitor on each wr_req rise or blocked pulse.
module tb_sprite_loc_ctrl;
  localparam int NS = 4;
  localparam int XW = 6;
  localparam int YW = 5;
  localparam int IW = 2;

  typedef struct packed {
    logic          kind;   // 0 = write, 1 = blocked
    logic [IW-1:0] id;
    logic [XW-1:0] ox;
    logic [YW-1:0] oy;
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [4*NS-1:0]   dir = '0;
  logic              blocked;
  logic [IW-1:0]     blocked_id;
  logic [NS*XW-1:0]  curr_x;
  logic [NS*YW-1:0]  curr_y;
  logic              busy;

  logic              model_done = 1'b0;
  logic              manual_done = 1'b0;
  logic              auto_done = 1'b1;
  int                wr_age = 0;

  int n_vec = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  logic [XW-1:0] last_rd_x = '0;
  logic [YW-1:0] last_rd_y = '0;
  logic prev_wr = 1'b0;
  exp_t exp_q[$];

  sprite_loc_ctrl_if #(.X_W(XW), .Y_W(YW), .ID_W(IW)) bus ();

  sprite_loc_ctrl #(
    .NUM_SPR (NS),
    .X_W     (XW),
    .Y_W     (YW),
    .MAP_W   (40),
    .MAP_H   (30),
    .START_XY({6'd0, 5'd7, 6'd10, 5'd5, 6'd20, 5'd20, 6'd20, 5'd20}),
    .ID_W    (IW)
  ) dut (
    .CLOCK_50  (clk),
    .reset_n   (reset_n),
    .dir       (dir),
    .bus       (bus),
    .blocked   (blocked),
    .blocked_id(blocked_id),
    .curr_x    (curr_x),
    .curr_y    (curr_y),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  assign bus.done = model_done | manual_done;

  // Wall map with one wall tile at (21,20); data follows the strobe by a cycle.
  always @(posedge clk) begin
    if (bus.wall_rd_en)
      bus.wall_rd_data <= (bus.wall_rd_x == 6'd21) && (bus.wall_rd_y == 5'd20);
    else
      bus.wall_rd_data <= 1'b0;
  end

  // RAM writer model: done one cycle, two cycles after wr_req rises.
  always @(posedge clk) begin
    if (!reset_n) begin
      wr_age     <= 0;
      model_done <= 1'b0;
    end else begin
      model_done <= 1'b0;
      if (bus.wr_req && !model_done) begin
        wr_age <= wr_age + 1;
        if (wr_age == 1 && auto_done) model_done <= 1'b1;
      end else begin
        wr_age <= 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t wr_exp(input int id, input int ox, input int oy, input int nx, input int ny);
    exp_t e;
    e.kind = 1'b0; e.id = IW'(id);
    e.ox = XW'(ox); e.oy = YW'(oy); e.nx = XW'(nx); e.ny = YW'(ny);
    return e;
  endfunction

  function automatic exp_t blk_exp(input int id);
    exp_t e;
    e = '0;
    e.kind = 1'b1; e.id = IW'(id);
    return e;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a move or rejection.
  always @(negedge clk) begin
    exp_t act;
    exp_t e;
    if (bus.wall_rd_en) begin
      rd_cnt++;
      last_rd_x = bus.wall_rd_x;
      last_rd_y = bus.wall_rd_y;
    end
    if (bus.wr_req && !prev_wr) begin
      wr_cnt++;
      act = '{1'b0, bus.wr_id, bus.wr_old_x, bus.wr_old_y, bus.wr_new_x, bus.wr_new_y};
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      check("wr_txn", 32'(act), 32'(e));
    end
    if (blocked) begin
      act = blk_exp(int'(blocked_id));
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      check("blocked_txn", 32'(act), 32'(e));
    end
    prev_wr = bus.wr_req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || bus.wr_req) && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) check({name, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic run_move(input int id, input logic [3:0] d, input string name);
    int n;
    dir = '0;
    dir[4*id +: 4] = d;
    n = 0;
    do begin
      tick();
      n++;
    end while (!blocked && !bus.wr_req && n < 60);
    if (n >= 60) check({name, "_timeout"}, 32'd0, 32'd1);
    dir = '0;
    wait_idle(name);
  endtask

  function automatic int cx(input int i);
    return int'(curr_x[i*XW +: XW]);
  endfunction

  function automatic int cy(input int i);
    return int'(curr_y[i*YW +: YW]);
  endfunction

  initial begin
    int base_wr;
    int base_rd;
    int n;

    // Reset state
    bus.wall_rd_data = 1'b0;
    tick();
    do_reset();
    check("rst_x0", 32'(cx(0)), 32'd20);
    check("rst_y0", 32'(cy(0)), 32'd20);
    check("rst_x3", 32'(cx(3)), 32'd0);
    check("rst_y3", 32'(cy(3)), 32'd7);
    check("rst_wr_req", 32'(bus.wr_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_en", 32'(bus.wall_rd_en), 32'd0);

    // Single move, sprite0 up, with cycle-exact timing
    exp_q.push_back(wr_exp(0, 20, 20, 20, 19));
    dir = 16'h0008;
    tick();
    check("mv_rd_en", 32'(bus.wall_rd_en), 32'd1);
    check("mv_rd_xy", {26'd0, bus.wall_rd_x} * 32'd32 + 32'(bus.wall_rd_y), 32'd20 * 32'd32 + 32'd19);
    check("mv_busy", 32'(busy), 32'd1);
    dir = '0;
    tick();
    check("mv_wr_req_wait", 32'(bus.wr_req), 32'd0);
    tick();
    check("mv_wr_req_write", 32'(bus.wr_req), 32'd1);
    wait_idle("mv");
    check("mv_x0", 32'(cx(0)), 32'd20);
    check("mv_y0", 32'(cy(0)), 32'd19);

    // Wall: sprite1 right into (21,20)
    base_wr = wr_cnt;
    exp_q.push_back(blk_exp(1));
    run_move(1, 4'b0001, "wall");
    check("wall_rd_x", 32'(last_rd_x), 32'd21);
    check("wall_no_wr", 32'(wr_cnt - base_wr), 32'd0);
    check("wall_x1", 32'(cx(1)), 32'd20);
    check("wall_y1", 32'(cy(1)), 32'd20);
    tick();
    check("wall_pulse_len", 32'(blocked), 32'd0);

    // Round-robin among sprites 0,2,3 requesting continuously
    do_reset();
    exp_q.push_back(wr_exp(0, 20, 20, 20, 19));
    exp_q.push_back(wr_exp(2, 10, 5, 10, 6));
    exp_q.push_back(wr_exp(3, 0, 7, 1, 7));
    exp_q.push_back(wr_exp(0, 20, 19, 20, 18));
    exp_q.push_back(wr_exp(2, 10, 6, 10, 7));
    exp_q.push_back(wr_exp(3, 1, 7, 2, 7));
    base_wr = wr_cnt;
    dir = 16'h1408;
    n = 0;
    while (wr_cnt < base_wr + 6 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("arb_timeout", 32'(wr_cnt - base_wr), 32'd6);
    dir = '0;
    wait_idle("arb");
    check("arb_y0", 32'(cy(0)), 32'd18);
    check("arb_y2", 32'(cy(2)), 32'd7);
    check("arb_x3", 32'(cx(3)), 32'd2);

    // Left edge: sprite3 at x=0 moves left
    do_reset();
    base_rd = rd_cnt;
`ifdef SPRITE_WRAP_EN
    exp_q.push_back(wr_exp(3, 0, 7, 39, 7));
    run_move(3, 4'b0010, "edge");
    check("edge_rd_x", 32'(last_rd_x), 32'd39);
    check("edge_x3", 32'(cx(3)), 32'd39);
`else
    exp_q.push_back(blk_exp(3));
    run_move(3, 4'b0010, "edge");
    check("edge_no_rd", 32'(rd_cnt - base_rd), 32'd0);
    check("edge_x3", 32'(cx(3)), 32'd0);
`endif

    // Reset in the middle of WRITE, then a stray done
    auto_done = 1'b0;
    exp_q.push_back(wr_exp(0, 20, 20, 20, 21));
    dir = 16'h0004;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.wr_req && n < 60);
    if (n >= 60) check("rstw_timeout", 32'd0, 32'd1);
    dir = '0;
    tick();
    tick();
    check("rstw_held", 32'(bus.wr_req), 32'd1);
    do_reset();
    check("rstw_wr_req", 32'(bus.wr_req), 32'd0);
    check("rstw_busy", 32'(busy), 32'd0);
    check("rstw_y0", 32'(cy(0)), 32'd20);
    manual_done = 1'b1;
    tick();
    manual_done = 1'b0;
    tick();
    check("stray_done_y0", 32'(cy(0)), 32'd20);
    check("stray_done_busy", 32'(busy), 32'd0);
    auto_done = 1'b1;

    tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/sprite_loc_ctrl.md
# sprite_loc_ctrl

Parametrised location controller for up to NUM_SPR map sprites (pacman plus ghosts) on the tile map. Holds every sprite's current tile, arbitrates movement requests round-robin, checks the target tile against the wall map through a registered read port, and hands accepted moves to the map-RAM write module with a req/done handshake. It sits between the input/AI direction sources and the RAM writer.

## Interface
- NUM_SPR, 4, number of sprites (1..8)
- X_W, 6, x coordinate width
- Y_W, 5, y coordinate width
- MAP_W, 40, map width in tiles (≤ 2^X_W)
- MAP_H, 30, map height in tiles (≤ 2^Y_W)
- START_XY, {NUM_SPR{6'd20,5'd20}}, packed reset positions; sprite i occupies bits [i*(X_W+Y_W) +: X_W+Y_W] as {x,y}
- ID_W, $clog2(NUM_SPR) min 1, sprite id width (derived)

- CLOCK_50  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- dir  in  4*NUM_SPR  per-sprite {up,down,left,right}, sprite i at [4i+:4]
- wall_rd_en  out  1  wall-map read strobe
- wall_rd_x  out  X_W  wall-map read x
- wall_rd_y  out  Y_W  wall-map read y
- wall_rd_data  in  1  1 = wall; valid the cycle after wall_rd_en
- wr_req  out  1  move request to RAM writer
- wr_id  out  ID_W  sprite being moved
- wr_old_x / wr_old_y  out  X_W / Y_W  tile to clear
- wr_new_x / wr_new_y  out  X_W / Y_W  tile to draw
- done  in  1  RAM writer finished the move
- blocked  out  1  one-cycle pulse: request rejected (wall or edge)
- blocked_id  out  ID_W  sprite rejected
- curr_x  out  NUM_SPR*X_W  current x per sprite
- curr_y  out  NUM_SPR*Y_W  current y per sprite
- busy  out  1  FSM not in IDLE

## Operation
- States: IDLE, CHECK, WAIT, WRITE.
- IDLE: search sprites from rr_ptr upward (modulo NUM_SPR) for first with dir≠0; if found, latch id, direction (priority up>down>left>right), old and candidate coordinates; go CHECK. None found: stay.
- Candidate: up y-1, down y+1, left x-1, right x+1; arithmetic in coordinate width.
- Edge crossing (x=0 left, x=MAP_W-1 right, y=0 up, y=MAP_H-1 down): see Configuration; a rejected edge move pulses blocked in IDLE's exit cycle, rr_ptr←id+1, stays IDLE (no CHECK).
- CHECK: wall_rd_en=1, wall_rd_x/y=candidate; go WAIT.
- WAIT: sample wall_rd_data. 1: pulse blocked/blocked_id, rr_ptr←id+1, go IDLE. 0: go WRITE.
- WRITE: wr_req=1, wr_* stable until done. done=1: curr[id]←candidate, rr_ptr←id+1, go IDLE.
- done outside WRITE ignored. dir changes after latch do not affect the in-flight move.
- Outputs registered except busy (decoded from state).

## Timing
- Reset (reset_n=0 at an edge, any state): state IDLE, rr_ptr 0, curr from START_XY, wr_req 0, wall_rd_en 0, blocked 0, wr_*/blocked_id/wall_rd_x/y 0, busy 0. Aborts any in-flight move; writer must also be reset.
- Request seen in IDLE at edge n: CHECK cycle n+1, WAIT n+2, wr_req high from n+3.
- done high at edge m during WRITE: curr updated and wr_req low from m+1; IDLE at m+1; next arbitration same cycle, earliest next wr_req m+4.
- blocked pulse: cycle after WAIT (wall) or cycle after IDLE detection (edge); exactly one cycle.
- Simultaneous requests: served in rr order, one move in flight at a time; fairness: any continuously requesting sprite served within NUM_SPR moves.
- Sprites may overlap tiles; collision detection is not this block's job.

## Configuration
- SPRITE_WRAP_EN defined: edge crossings wrap (x=0 left→MAP_W-1, x=MAP_W-1 right→0, same for y with MAP_H) and proceed to CHECK like any move.
- Undefined: edge crossings rejected with blocked pulse, no wall read, curr unchanged.

## Test plan
- Reset: reset_n=0 one edge → curr all equal START_XY values (sprite0 (20,20)), wr_req 0, busy 0.
- Single move: sprite0 dir=up, wall_rd_data=0 → wall_rd at (20,19) cycle n+1, wr_req cycle n+3 with old (20,20) new (20,19); done pulse → curr0=(20,19), busy 0 next cycle.
- Wall: sprite1 dir=right, wall_rd_data=1 → blocked pulse id=1 one cycle, no wr_req, curr1 unchanged.
- Arbitration: sprites 0,2,3 requesting continuously, done returned 2 cycles after each wr_req → wr_id sequence 0,2,3,0,2,3.
- Edge: sprite at x=0, dir=left → with SPRITE_WRAP_EN wall read at x=39 and move to 39; without it blocked pulse, no wall_rd_en.
- Reset mid-WRITE: reset_n=0 while wr_req high → wr_req 0 next cycle, curr restored to START_XY, later done ignored.
